// File: rtl/tpu_mac_seq.sv
// Dot-product sequencer: issues one MAC request at a time and feeds each result back as the addend.
// Optional build macro MAC_SEQ_SKIP_ZERO_EN skips operand pairs containing a zero without a MAC request.
module tpu_mac_seq #(
    parameter int LEN_W       = 8,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic [2:0]       data_type_i,
    input  logic [31:0]      bias_i,
    input  logic             abort_i,
    input  logic             op_valid_i,
    output logic             op_ready_o,
    input  logic [15:0]      op_a_i,
    input  logic [15:0]      op_b_i,
    output logic             mac_enable_o,
    output logic [2:0]       mac_data_type_o,
    output logic [15:0]      mac_a_o,
    output logic [15:0]      mac_b_o,
    output logic [31:0]      mac_c_o,
    output logic             mac_valid_in_o,
    input  logic [31:0]      mac_result_i,
    input  logic             mac_valid_out_i,
    input  logic             mac_ready_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [31:0]      acc_out_o,
    output logic             err_o
);

    localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   count_q, count_d;
    logic [LEN_W-1:0]   countInc;
    logic [31:0]        acc_q, acc_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               timedOut_q, timedOut_d;
    logic               macEnable_q;
    logic [2:0]         dataType_q, dataType_d;
    logic [15:0]        macA_q, macA_d;
    logic [15:0]        macB_q, macB_d;
    logic [31:0]        macC_q, macC_d;
    logic               macValidIn_q, macValidIn_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [31:0]        accOut_q, accOut_d;
    logic               err_q, err_d;
    logic               skipPair;

    assign countInc = count_q + LEN_W'(1);

    always_comb begin
`ifdef MAC_SEQ_SKIP_ZERO_EN
        skipPair = (op_a_i == 16'd0) || (op_b_i == 16'd0);
`else
        skipPair = 1'b0;
`endif
    end

    // Timeout is remembered separately so err only becomes visible together with done.
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        count_d      = count_q;
        acc_d        = acc_q;
        timer_d      = timer_q;
        timedOut_d   = timedOut_q;
        dataType_d   = dataType_q;
        macA_d       = macA_q;
        macB_d       = macB_q;
        macC_d       = macC_q;
        macValidIn_d = 1'b0;
        busy_d       = busy_q;
        done_d       = 1'b0;
        accOut_d     = accOut_q;
        err_d        = err_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    len_d      = len_i;
                    dataType_d = data_type_i;
                    acc_d      = bias_i;
                    count_d    = '0;
                    timedOut_d = 1'b0;
                    err_d      = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = (len_i == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (op_valid_i && mac_ready_i) begin
                    if (skipPair) begin
                        count_d = countInc;
                        if (countInc == len_q) begin
                            state_d = DONE;
                        end
                    end else begin
                        macA_d       = op_a_i;
                        macB_d       = op_b_i;
                        macC_d       = acc_q;
                        macValidIn_d = 1'b1;
                        timer_d      = '0;
                        state_d      = WAIT;
                    end
                end
            end
            WAIT: begin
                if (mac_valid_out_i) begin
                    acc_d   = mac_result_i;
                    count_d = countInc;
                    state_d = (countInc == len_q) ? DONE : ISSUE;
                end else if (timer_q == TMR_LAST) begin
                    timedOut_d = 1'b1;
                    state_d    = DONE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            DONE: begin
                accOut_d = acc_q;
                err_d    = timedOut_q;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (abort_i && (state_q != IDLE)) begin
            state_d      = IDLE;
            busy_d       = 1'b0;
            done_d       = 1'b0;
            macValidIn_d = 1'b0;
            macA_d       = macA_q;
            macB_d       = macB_q;
            macC_d       = macC_q;
            accOut_d     = accOut_q;
            err_d        = err_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            len_q        <= '0;
            count_q      <= '0;
            acc_q        <= '0;
            timer_q      <= '0;
            timedOut_q   <= 1'b0;
            macEnable_q  <= 1'b0;
            dataType_q   <= '0;
            macA_q       <= '0;
            macB_q       <= '0;
            macC_q       <= '0;
            macValidIn_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            accOut_q     <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            count_q      <= count_d;
            acc_q        <= acc_d;
            timer_q      <= timer_d;
            timedOut_q   <= timedOut_d;
            macEnable_q  <= 1'b1;
            dataType_q   <= dataType_d;
            macA_q       <= macA_d;
            macB_q       <= macB_d;
            macC_q       <= macC_d;
            macValidIn_q <= macValidIn_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            accOut_q     <= accOut_d;
            err_q        <= err_d;
        end
    end

    assign op_ready_o      = (state_q == ISSUE) && mac_ready_i;
    assign mac_enable_o    = macEnable_q;
    assign mac_data_type_o = dataType_q;
    assign mac_a_o         = macA_q;
    assign mac_b_o         = macB_q;
    assign mac_c_o         = macC_q;
    assign mac_valid_in_o  = macValidIn_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign acc_out_o       = accOut_q;
    assign err_o           = err_q;

endmodule

// File: tb/tb_tpu_mac_seq.sv
// Testbench for tpu_mac_seq: directed and randomized commands against a MAC responder and a dot-product reference.
module tb_tpu_mac_seq;

    localparam int LEN_W = 8;
    localparam int TMO   = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] len;
    logic [2:0]       dataType;
    logic [31:0]      bias;
    logic             abort;
    logic             opValid;
    logic             opReady;
    logic [15:0]      opA, opB;
    logic             macEnable;
    logic [2:0]       macDataType;
    logic [15:0]      macA, macB;
    logic [31:0]      macC;
    logic             macValidIn;
    logic [31:0]      macResult = '0;
    logic             macValidOut = 1'b0;
    logic             macReady;
    logic             busy, done, err;
    logic [31:0]      accOut;

    tpu_mac_seq #(.LEN_W(LEN_W), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .start_i(start), .len_i(len), .data_type_i(dataType),
        .bias_i(bias), .abort_i(abort), .op_valid_i(opValid), .op_ready_o(opReady),
        .op_a_i(opA), .op_b_i(opB), .mac_enable_o(macEnable), .mac_data_type_o(macDataType),
        .mac_a_o(macA), .mac_b_o(macB), .mac_c_o(macC), .mac_valid_in_o(macValidIn),
        .mac_result_i(macResult), .mac_valid_out_i(macValidOut), .mac_ready_i(macReady),
        .busy_o(busy), .done_o(done), .acc_out_o(accOut), .err_o(err)
    );

    always #5 clk = ~clk;

    int compCount = 0;
    int failCount = 0;

    logic [15:0] refA[$];
    logic [15:0] refB[$];
    logic [15:0] capA[$];
    logic [15:0] capB[$];
    logic [31:0] capC[$];

    bit   macSilent = 1'b0;
    int   macCountdown = 0;
    logic [31:0] macPending = '0;
    logic prevValidIn = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] prod(input logic [15:0] a, input logic [15:0] b);
        return 32'(int'($signed(a)) * int'($signed(b)));
    endfunction

    function automatic bit isSkipped(input logic [15:0] a, input logic [15:0] b);
`ifdef MAC_SEQ_SKIP_ZERO_EN
        return (a == 16'd0) || (b == 16'd0);
`else
        return 1'b0;
`endif
    endfunction

    // MAC responder: answers c + a*b after a random latency unless silenced.
    always @(negedge clk) begin
        macValidOut = 1'b0;
        if (rst) begin
            macCountdown = 0;
        end else begin
            if (macCountdown > 0) begin
                macCountdown--;
                if (macCountdown == 0) begin
                    macValidOut = 1'b1;
                    macResult   = macPending;
                end
            end
            if (macValidIn && !macSilent) begin
                macPending   = macC + prod(macA, macB);
                macCountdown = $urandom_range(1, 4);
            end
        end
    end

    always @(negedge clk) begin
        if (macValidIn) begin
            capA.push_back(macA);
            capB.push_back(macB);
            capC.push_back(macC);
            checkOutput("valid_in_single_cycle", prevValidIn, 1'b0);
        end
        prevValidIn = macValidIn;
    end

    task automatic applyStimulus(input logic [31:0] cmdBias, input logic [LEN_W-1:0] cmdLen,
                                 input logic [2:0] cmdType, input int budget,
                                 output int doneCyc, output int issueCyc);
        int idx = 0;
        int cyc = 0;
        bit seen = 1'b0;
        capA.delete();
        capB.delete();
        capC.delete();
        doneCyc  = -1;
        issueCyc = -1;
        @(posedge clk); #1;
        start = 1'b1; len = cmdLen; dataType = cmdType; bias = cmdBias;
        while (cyc < budget && !seen) begin
            @(posedge clk); #1;
            start    = 1'b0;
            macReady = ($urandom_range(0, 3) != 0);
            if (idx < int'(cmdLen)) begin
                opValid = ($urandom_range(0, 3) != 0);
                opA     = refA[idx];
                opB     = refB[idx];
            end else begin
                opValid = 1'b0;
            end
            @(negedge clk);
            cyc++;
            if (opValid && opReady) idx++;
            if (macValidIn && issueCyc < 0) issueCyc = cyc;
            if (done) begin
                seen    = 1'b1;
                doneCyc = cyc;
            end
        end
        opValid = 1'b0;
        checkOutput("done_seen", seen, 1'b1);
    endtask

    task automatic verifyCmd(input string tag, input logic [31:0] cmdBias, input logic [2:0] cmdType);
        logic [31:0] acc = cmdBias;
        int k = 0;
        int expReq = 0;
        foreach (refA[i]) if (!isSkipped(refA[i], refB[i])) expReq++;
        checkOutput({tag, "_req_count"}, capC.size(), expReq);
        foreach (refA[i]) begin
            if (!isSkipped(refA[i], refB[i])) begin
                if (k < capC.size()) begin
                    checkOutput({tag, "_mac_a"}, capA[k], refA[i]);
                    checkOutput({tag, "_mac_b"}, capB[k], refB[i]);
                    checkOutput({tag, "_mac_c"}, capC[k], acc);
                end
                acc = acc + prod(refA[i], refB[i]);
                k++;
            end
        end
        checkOutput({tag, "_acc_out"}, accOut, acc);
        checkOutput({tag, "_err"}, err, 1'b0);
        checkOutput({tag, "_busy_at_done"}, busy, 1'b0);
        checkOutput({tag, "_data_type"}, macDataType, cmdType);
    endtask

    initial begin
        int doneCyc, issueCyc, cyc;
        bit sawDone, sawIssue;
        logic [31:0] expC [3] = '{32'd100, 32'd156, 32'd216};
        logic [31:0] lastAcc;

        rst = 1'b1; start = 1'b0; len = '0; dataType = '0; bias = '0; abort = 1'b0;
        opValid = 1'b0; opA = '0; opB = '0; macReady = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_flags", {busy, done, err, macValidIn, opReady, macEnable}, 6'b0);
        checkOutput("reset_acc_out", accOut, 32'd0);
        checkOutput("reset_mac_abc", {macA, macB, macDataType}, 35'd0);
        checkOutput("reset_mac_c", macC, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("mac_enable_still_low", macEnable, 1'b0);
        @(negedge clk);
        checkOutput("mac_enable_high", macEnable, 1'b1);

        $display("[TB] test 1: single pair");
        refA = '{16'd10}; refB = '{16'd20};
        applyStimulus(32'd5, 8'd1, 3'b000, 60, doneCyc, issueCyc);
        verifyCmd("t1", 32'd5, 3'b000);
        checkOutput("t1_acc_205", accOut, 32'd205);
        @(negedge clk);
        checkOutput("t1_done_one_cycle", done, 1'b0);

        $display("[TB] test 2: three pairs");
        refA = '{16'd7, 16'd15, 16'd2}; refB = '{16'd8, 16'd4, 16'd3};
        applyStimulus(32'd100, 8'd3, 3'b001, 120, doneCyc, issueCyc);
        verifyCmd("t2", 32'd100, 3'b001);
        for (int i = 0; i < 3; i++)
            checkOutput("t2_mac_c_seq", (i < capC.size()) ? capC[i] : 32'hxxxx_xxxx, expC[i]);
        checkOutput("t2_acc_222", accOut, 32'd222);

        $display("[TB] test 3: zero length");
        refA.delete(); refB.delete();
        applyStimulus(32'd42, 8'd0, 3'b010, 20, doneCyc, issueCyc);
        checkOutput("t3_done_latency", doneCyc, 2);
        checkOutput("t3_no_request", capC.size(), 0);
        checkOutput("t3_acc_42", accOut, 32'd42);

        $display("[TB] test 4: timeout");
        macSilent = 1'b1;
        refA = '{16'd4}; refB = '{16'd5};
        applyStimulus(32'd7, 8'd1, 3'b000, 80, doneCyc, issueCyc);
        checkOutput("t4_err", err, 1'b1);
        checkOutput("t4_acc_bias", accOut, 32'd7);
        checkOutput("t4_timeout_window",
                    (issueCyc > 0) && (doneCyc - issueCyc >= TMO) && (doneCyc - issueCyc <= TMO + 2), 1'b1);
        @(negedge clk);
        checkOutput("t4_err_held", err, 1'b1);
        macSilent = 1'b0;
        refA.delete(); refB.delete();
        applyStimulus(32'd9, 8'd0, 3'b000, 20, doneCyc, issueCyc);
        checkOutput("t4_err_cleared", err, 1'b0);
        checkOutput("t4_acc_9", accOut, 32'd9);
        lastAcc = 32'd9;

        $display("[TB] test 5: abort then reset");
        @(posedge clk); #1;
        start = 1'b1; len = 8'd2; bias = 32'd11; dataType = 3'b000;
        macReady = 1'b1; opA = 16'd3; opB = 16'd4;
        sawIssue = 1'b0;
        cyc = 0;
        while (cyc < 40 && !sawIssue) begin
            @(posedge clk); #1;
            start = 1'b0;
            opValid = 1'b1;
            @(negedge clk);
            cyc++;
            if (macValidIn) sawIssue = 1'b1;
        end
        checkOutput("t5_issue_seen", sawIssue, 1'b1);
        @(posedge clk); #1;
        opValid = 1'b0; abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        sawDone = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) sawDone = 1'b1;
        end
        checkOutput("t5_abort_no_done", sawDone, 1'b0);
        checkOutput("t5_abort_busy", busy, 1'b0);
        checkOutput("t5_abort_acc_held", accOut, lastAcc);
        checkOutput("t5_abort_err_held", err, 1'b0);

        @(posedge clk); #1;
        start = 1'b1; len = 8'd2; bias = 32'd77;
        @(posedge clk); #1;
        start = 1'b0; opValid = 1'b1; opA = 16'd5; opB = 16'd6;
        @(posedge clk); #1;
        opValid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("t5_rst_flags", {busy, done, err, macValidIn, opReady, macEnable}, 6'b0);
        checkOutput("t5_rst_acc_out", accOut, 32'd0);
        checkOutput("t5_rst_mac_c", macC, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        refA = '{16'd3}; refB = '{16'd3};
        applyStimulus(32'd1, 8'd1, 3'b000, 60, doneCyc, issueCyc);
        verifyCmd("t5_after_rst", 32'd1, 3'b000);
        checkOutput("t5_acc_10", accOut, 32'd10);

        $display("[TB] test 6: zero operand");
        refA = '{16'd0}; refB = '{16'd999};
        applyStimulus(32'd42, 8'd1, 3'b000, 60, doneCyc, issueCyc);
        verifyCmd("t6", 32'd42, 3'b000);
        checkOutput("t6_acc_42", accOut, 32'd42);

        $display("[TB] randomized commands");
        for (int r = 0; r < 8; r++) begin
            logic [31:0] rBias;
            logic [2:0]  rType;
            int n;
            n = $urandom_range(1, 6);
            rBias = $urandom;
            rType = 3'($urandom_range(0, 2));
            refA.delete(); refB.delete();
            for (int i = 0; i < n; i++) begin
                refA.push_back(($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom));
                refB.push_back(16'($urandom));
            end
            applyStimulus(rBias, LEN_W'(n), rType, 300, doneCyc, issueCyc);
            verifyCmd("rand", rBias, rType);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, failCount);
        $finish;
    end

endmodule
